// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : calc_pkg
//  Description: Shared types for the calculator datapath. active_button_t
//               is the key code passed from the keypad scanner to the
//               controller.
//  Revision   : 1.0 - initial release
// ============================================================================
package calc_pkg;

    typedef enum logic [4:0] {
        B_NONE,
        B_ON,
        B_NUM_0,
        B_NUM_1,
        B_NUM_2,
        B_NUM_3,
        B_NUM_4,
        B_NUM_5,
        B_NUM_6,
        B_NUM_7,
        B_NUM_8,
        B_NUM_9,
        B_DOT,
        B_EQ,
        B_OP_ADD,
        B_OP_SUB,
        B_OP_MUL,
        B_OP_DIV
    } active_button_t;

endpackage
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module     : keypad_scanner
//  Description: Scans a 4x5 key matrix one column at a time, synchronizes
//               and debounces the row returns, and emits one key code with
//               a single-cycle new_input_o pulse per accepted press.
//  Revision   : 1.0 - initial release
//
//  Parameters
//    ScanDwell       clock cycles each column is driven (>= 4)
//    DebounceCycles  stable cycles needed to accept a press/release (>= 2)
//
//  Ports
//    clk_i            in   1   system clock
//    rst_ni           in   1   asynchronous reset, active-low
//    row_i            in   4   row returns, pulled up, low = key closed
//    col_o            out  5   column drives, active-low, one-cold
//    active_button_o  out  5   code of the last accepted key (held)
//    new_input_o      out  1   one-cycle pulse, code valid in same cycle
// ============================================================================
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int ScanDwell      = 1000,
    parameter int DebounceCycles = 16
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [3:0]     row_i,
    output logic [4:0]     col_o,
    output active_button_t active_button_o,
    output logic           new_input_o
);

    localparam int NumRows = 4;
    localparam int NumCols = 5;
    localparam int DwellW  = $clog2(ScanDwell);
    localparam int DbW     = $clog2(DebounceCycles + 1);

    localparam logic [DwellW-1:0] DwellLast = DwellW'(ScanDwell - 1);
    localparam logic [DbW-1:0]    DbLast    = DbW'(DebounceCycles - 1);
    localparam logic [DbW-1:0]    DbFull    = DbW'(DebounceCycles);
    localparam logic [2:0]        ColLast   = 3'(NumCols - 1);

    typedef enum logic [1:0] {
        S_SCAN       = 2'd0,
        S_PRESS_DB   = 2'd1,
        S_HELD       = 2'd2,
        S_RELEASE_DB = 2'd3
    } state_t;

    state_t              state_q;
    logic [NumRows-1:0]  row_meta_q;
    logic [NumRows-1:0]  row_s_q;
    logic [2:0]          col_idx_q;
    logic [1:0]          row_idx_q;
    logic [DwellW-1:0]   dwell_q;
    logic [DbW-1:0]      db_q;
    logic [NumCols-1:0]  col_q;
    active_button_t      active_button_q;
    logic                new_input_q;

    logic                one_low_d;
    logic [1:0]          hit_row_d;
    logic [1:0]          lk_row_d;
    logic [5:0]          lookup_d;
    logic [2:0]          col_next_d;
    logic                row_match_d;
    logic                row_high_d;

    // Returns {valid, code} for matrix position (r, c).
    function automatic logic [5:0] key_lookup(input logic [1:0] r, input logic [2:0] c);
        logic [5:0] res;
        res = {1'b0, B_NONE};
        case ({r, c})
            5'b00_000: res = {1'b1, B_ON};
            5'b00_001: res = {1'b1, B_NUM_7};
            5'b00_010: res = {1'b1, B_NUM_8};
            5'b00_011: res = {1'b1, B_NUM_9};
            5'b00_100: res = {1'b1, B_OP_DIV};
            5'b01_001: res = {1'b1, B_NUM_4};
            5'b01_010: res = {1'b1, B_NUM_5};
            5'b01_011: res = {1'b1, B_NUM_6};
            5'b01_100: res = {1'b1, B_OP_MUL};
            5'b10_001: res = {1'b1, B_NUM_1};
            5'b10_010: res = {1'b1, B_NUM_2};
            5'b10_011: res = {1'b1, B_NUM_3};
            5'b10_100: res = {1'b1, B_OP_SUB};
            5'b11_001: res = {1'b1, B_NUM_0};
            5'b11_010: res = {1'b1, B_DOT};
            5'b11_011: res = {1'b1, B_EQ};
            5'b11_100: res = {1'b1, B_OP_ADD};
            default:   res = {1'b0, B_NONE};
        endcase
        return res;
    endfunction

    // Exactly one row low; more than one low is treated as ghosting.
    always_comb begin
        one_low_d = 1'b0;
        hit_row_d = 2'd0;
        case (row_s_q)
            4'b1110: begin one_low_d = 1'b1; hit_row_d = 2'd0; end
            4'b1101: begin one_low_d = 1'b1; hit_row_d = 2'd1; end
            4'b1011: begin one_low_d = 1'b1; hit_row_d = 2'd2; end
            4'b0111: begin one_low_d = 1'b1; hit_row_d = 2'd3; end
            default: begin one_low_d = 1'b0; hit_row_d = 2'd0; end
        endcase
    end

    // While scanning, look up the candidate row; afterwards the latched one.
    always_comb begin
        lk_row_d    = (state_q == S_SCAN) ? hit_row_d : row_idx_q;
        lookup_d    = key_lookup(lk_row_d, col_idx_q);
        col_next_d  = (col_idx_q == ColLast) ? 3'd0 : col_idx_q + 3'd1;
        row_match_d = (row_s_q == ~(4'b0001 << row_idx_q));
        row_high_d  = row_s_q[row_idx_q];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= S_SCAN;
            row_meta_q      <= 4'b1111;
            row_s_q         <= 4'b1111;
            col_idx_q       <= 3'd0;
            row_idx_q       <= 2'd0;
            dwell_q         <= '0;
            db_q            <= '0;
            col_q           <= 5'b11110;
            active_button_q <= B_ON;
            new_input_q     <= 1'b0;
        end else begin
            row_meta_q  <= row_i;
            row_s_q     <= row_meta_q;
            // Column drive lags col_idx_q by one cycle.
            col_q       <= ~(5'b00001 << col_idx_q);
            new_input_q <= 1'b0;

            case (state_q)
                S_SCAN: begin
                    if (dwell_q == DwellLast) begin
                        if (one_low_d && lookup_d[5]) begin
                            row_idx_q <= hit_row_d;
                            db_q      <= DbW'(1);
                            dwell_q   <= '0;
                            state_q   <= S_PRESS_DB;
                        end else begin
                            col_idx_q <= col_next_d;
                            dwell_q   <= '0;
                        end
                    end else begin
                        dwell_q <= dwell_q + DwellW'(1);
                    end
                end

                S_PRESS_DB: begin
                    if (row_match_d) begin
                        if (db_q == DbLast) begin
                            db_q            <= DbFull;
                            active_button_q <= active_button_t'(lookup_d[4:0]);
                            new_input_q     <= 1'b1;
                            state_q         <= S_HELD;
                        end else if (db_q != DbFull) begin
                            db_q <= db_q + DbW'(1);
                        end
                    end else begin
                        col_idx_q <= col_next_d;
                        dwell_q   <= '0;
                        db_q      <= '0;
                        state_q   <= S_SCAN;
                    end
                end

                S_HELD: begin
                    // Other rows are deliberately ignored here.
                    if (row_high_d) begin
                        db_q    <= DbW'(1);
                        state_q <= S_RELEASE_DB;
                    end
                end

                S_RELEASE_DB: begin
                    if (row_high_d) begin
                        if (db_q == DbLast) begin
                            col_idx_q <= col_next_d;
                            dwell_q   <= '0;
                            db_q      <= '0;
                            state_q   <= S_SCAN;
                        end else if (db_q != DbFull) begin
                            db_q <= db_q + DbW'(1);
                        end
                    end else begin
                        state_q <= S_HELD;
                    end
                end

                default: state_q <= S_SCAN;
            endcase
        end
    end

    assign col_o           = col_q;
    assign active_button_o = active_button_q;
    assign new_input_o     = new_input_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module     : tb_keypad_scanner
//  Description: Directed self-checking bench for keypad_scanner with a
//               behavioural key-matrix model (ScanDwell=4, DebounceCycles=3).
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;
    import calc_pkg::*;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     row;
    logic [4:0]     col;
    active_button_t btn;
    logic           nin;

    // key[r][c] = 1 means the switch at row r, column c is closed.
    logic [4:0] key [4] = '{default: 5'b0};

    int checks   = 0;
    int failures = 0;

    int             pulses    = 0;
    int             cyc       = 0;
    int             pulse_cyc = 0;
    int             back2back = 0;
    logic           prev_nin  = 1'b0;

    keypad_scanner #(
        .ScanDwell      (4),
        .DebounceCycles (3)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .row_i           (row),
        .col_o           (col),
        .active_button_o (btn),
        .new_input_o     (nin)
    );

    always #5 clk = ~clk;

    // Pulled-up rows: low when any closed switch sits in a driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) row[r] = ~|(key[r] & ~col);
    end

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (nin === 1'b1) begin
            pulses    = pulses + 1;
            pulse_cyc = cyc;
            if (prev_nin === 1'b1) back2back = back2back + 1;
        end
        prev_nin = nin;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_col(input logic [4:0] target, input int budget, input string tag);
        int n = 0;
        while (col !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {27'd0, col}, {27'd0, target});
    endtask

    task automatic clear_keys();
        for (int r = 0; r < 4; r++) key[r] = 5'b0;
    endtask

    initial begin
        int base;
        int bounce_end;
        int n;

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        tick(2);
        chk("reset col", {27'd0, col}, 32'h1E);
        chk("reset new_input", {31'd0, nin}, 32'd0);
        chk("reset code", {27'd0, btn}, {27'd0, B_ON});
        rst_n = 1'b1;
        tick(10);

        // ---------------- r2c1 long hold, then re-press ----------------
        base = pulses;
        key[2][1] = 1'b1;
        tick(200);
        chk("r2c1 one pulse", pulses - base, 32'd1);
        chk("r2c1 code", {27'd0, btn}, {27'd0, B_NUM_1});
        chk("r2c1 column held", {27'd0, col}, 32'h1D);
        key[2][1] = 1'b0;
        tick(20);
        key[2][1] = 1'b1;
        tick(100);
        chk("r2c1 second pulse", pulses - base, 32'd2);
        chk("r2c1 second code", {27'd0, btn}, {27'd0, B_NUM_1});
        clear_keys();
        tick(20);

        // ---------------- reset during press debounce ----------------
        base = pulses;
        key[2][2] = 1'b1;
        wait_col(5'b11110, 40, "pre-reset reach col0");
        wait_col(5'b11011, 40, "pre-reset reach col2");
        // Dwell ends three edges later; that edge enters press debounce.
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midpress reset col", {27'd0, col}, 32'h1E);
        chk("midpress reset new_input", {31'd0, nin}, 32'd0);
        chk("midpress reset code", {27'd0, btn}, {27'd0, B_ON});
        chk("midpress no early pulse", pulses - base, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("post-reset col0", {27'd0, col}, 32'h1E);
        tick(60);
        chk("post-reset redetect pulse", pulses - base, 32'd1);
        chk("post-reset redetect code", {27'd0, btn}, {27'd0, B_NUM_2});
        clear_keys();
        tick(20);

        // ---------------- r3c4 bounce ----------------
        base = pulses;
        for (int i = 0; i < 6; i++) begin
            key[3][4] = (i % 2 == 0);
            tick(2);
        end
        key[3][4] = 1'b1;
        bounce_end = cyc;
        tick(80);
        chk("bounce one pulse", pulses - base, 32'd1);
        chk("bounce code", {27'd0, btn}, {27'd0, B_OP_ADD});
        chk("bounce pulse after settle", {31'd0, (pulse_cyc - bounce_end) >= 3}, 32'd1);
        clear_keys();
        tick(20);

        // ---------------- ghosting r0+r1 in column 3 ----------------
        base = pulses;
        key[0][3] = 1'b1;
        key[1][3] = 1'b1;
        wait_col(5'b10111, 40, "ghost reach col3");
        wait_col(5'b01111, 10, "ghost advance col4");
        wait_col(5'b11110, 10, "ghost wrap col0");
        tick(100);
        chk("ghost no pulse", pulses - base, 32'd0);
        clear_keys();
        tick(20);

        // ---------------- unused r1c0 ----------------
        base = pulses;
        key[1][0] = 1'b1;
        tick(100);
        chk("unused no pulse", pulses - base, 32'd0);
        wait_col(5'b11110, 30, "unused scan col0");
        wait_col(5'b11101, 10, "unused scan col1");
        clear_keys();
        tick(20);

        // ---------------- r0c0 with glitches while held ----------------
        base = pulses;
        key[0][0] = 1'b1;
        n = 0;
        while ((pulses - base) < 1 && n < 60) begin
            tick(1);
            n++;
        end
        tick(10);
        key[0][0] = 1'b0;
        tick(1);
        key[0][0] = 1'b1;
        tick(10);
        key[0][0] = 1'b0;
        tick(2);
        key[0][0] = 1'b1;
        tick(10);
        chk("glitch one pulse", pulses - base, 32'd1);
        chk("glitch code", {27'd0, btn}, {27'd0, B_ON});
        chk("glitch col held", {27'd0, col}, 32'h1E);
        tick(30);
        chk("glitch still held", {27'd0, col}, 32'h1E);
        clear_keys();
        tick(20);

        chk("no back-to-back pulses", back2back, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the calculator's 4x5 key matrix, synchronizes and debounces the row returns, and converts each clean key press into a `calc_pkg::active_button_t` code with a one-cycle `new_input_o` pulse. It sits directly upstream of `controller`. `active_button_o` drives `active_button_i` and `new_input_o` drives `new_input_i`. One press produces exactly one pulse, regardless of hold time or contact bounce.

## Interface
- `ScanDwell`, default 1000: clock cycles each column is driven; must be ≥ 4.
- `DebounceCycles`, default 16: consecutive stable cycles required to accept a press or a release; must be ≥ 2.
- Matrix size is fixed: 4 rows × 5 columns (localparams `NumRows`, `NumCols`).
- `clk_i`  in  1  system clock. One clock domain.
- `rst_ni`  in  1  asynchronous reset, active-low.
- `row_i`  in  4  row returns from the pins. Asynchronous, pulled up; low = key closed in the driven column.
- `col_o`  out  5  column drives, active-low. Exactly one bit is low at all times.
- `active_button_o`  out  `calc_pkg::active_button_t`  code of the last accepted key. Held between presses.
- `new_input_o`  out  1  one-cycle pulse; `active_button_o` is valid in the same cycle.

## Operation
- **Synchronizer:** `row_i` passes through a 2-flop synchronizer. All decisions use the synchronized value `row_s`.
- **Key map** (row r, col c):
  - r0: `B_ON`, `B_NUM_7`, `B_NUM_8`, `B_NUM_9`, `B_OP_DIV`
  - r1: unused, `B_NUM_4`, `B_NUM_5`, `B_NUM_6`, `B_OP_MUL`
  - r2: unused, `B_NUM_1`, `B_NUM_2`, `B_NUM_3`, `B_OP_SUB`
  - r3: unused, `B_NUM_0`, `B_DOT`, `B_EQ`, `B_OP_ADD`
  - Unused positions never pulse.
- **State machine:**
  - `S_SCAN`:
    - Drives column `col_idx` low. A dwell counter runs 0..`ScanDwell`-1.
    - At count `ScanDwell`-1, sample `row_s`:
      - Exactly one row low and the position is mapped: latch `row_idx`, set the debounce counter to 1, go to `S_PRESS_DB`. `col_idx` is held.
      - Otherwise (zero rows low, ≥2 rows low as ghosting/multi-press, or an unmapped position): advance `col_idx`, wrapping 4→0, and clear the dwell counter.
  - `S_PRESS_DB`:
    - Each cycle, check whether `row_s` equals the one-hot-low pattern of `row_idx`.
    - Match: the counter increments. When it reaches `DebounceCycles`, go to `S_HELD`, load `active_button_o` from the map, and assert `new_input_o`. Both update on the same edge.
    - Mismatch: return to `S_SCAN`, advance the column, clear counters. No pulse.
  - `S_HELD`:
    - Column stays driven.
    - When the `row_idx` row reads high, set the counter to 1 and go to `S_RELEASE_DB`.
    - Other rows are ignored.
  - `S_RELEASE_DB`:
    - `row_idx` row high: the counter increments. When it reaches `DebounceCycles`, go to `S_SCAN` on the next column with the dwell counter cleared.
    - `row_idx` row low: return to `S_HELD` with no pulse.
- **Pulse behaviour:** `new_input_o` is high for exactly one cycle per accepted press. There is no queueing. If the consumer is busy, the pulse is lost by design.
- **Counter widths:** `$clog2(ScanDwell)` and `$clog2(DebounceCycles+1)` bits. Counters saturate at their terminal count and never wrap.

## Timing
- **Reset values** (asynchronous, on `rst_ni` low):
  - `col_o` = 5'b11110 (col 0), `new_input_o` = 0, `active_button_o` = `B_ON`.
  - State `S_SCAN`, all counters 0, synchronizer flops = 4'b1111.
- **Reset mid-press:** outputs take their reset values immediately. After release of `rst_ni`, scanning restarts at col 0. A key still held is re-detected and pulses once.
- **Press latency:**
  - Pin-to-`row_s` is 2 cycles.
  - From the `S_SCAN` sample cycle, the pulse appears `DebounceCycles`-1 cycles later, registered.
  - Worst case from a stable press to the pulse: 5·`ScanDwell` + `DebounceCycles` + 2 cycles.
- **Column settling:** a column change takes effect on `col_o` the cycle after `col_idx` updates. Sampling only at dwell end allows 3+ cycles for pin settle plus synchronizer.
- **Simultaneous keys:**
  - A second key pressed while in `S_HELD` is ignored.
  - After release, the scan resumes at the next column; the second key, if still held, is then accepted.

## Test plan
Bench settings: `ScanDwell`=4, `DebounceCycles`=3.
- Reset with `rst_ni` low mid-`S_PRESS_DB` -> same-cycle `col_o`=11110, `new_input_o`=0, `active_button_o`=`B_ON`. Scan resumes at col 0 after release.
- Hold r2c1 low for 200 cycles -> exactly one pulse with `active_button_o`=`B_NUM_1`. Release ≥3 cycles and press again -> a second pulse.
- r3c4 bouncing (toggle every 2 cycles for 12 cycles, then stable low) -> exactly one `B_OP_ADD` pulse, ≥3 stable cycles after the last bounce.
- r0 and r1 both low in column 3 -> no pulse. `col_o` keeps rotating 3→4→0.
- r1c0 (unused) held low -> no pulse ever. Scanning continues.
- r0c0 held, 1-cycle high glitch in `S_HELD`, then 2-cycle high glitch -> one `B_ON` pulse total. The FSM returns to `S_HELD` both times.
